// File: rtl/win22_a_if.sv
// rtl/win22_a_if.sv - tile/result bundle for the Winograd F(2x2,3x3) output transform
interface win22_a_if;
    logic        enable;
    logic        first;
    logic [1:0]  bitwidth;
    logic [63:0] m_row1;
    logic [63:0] m_row2;
    logic [63:0] m_row3;
    logic [63:0] m_row4;
    logic [63:0] y_out;
    logic        done;
    logic        busy;

    modport master (
        output enable, first, bitwidth, m_row1, m_row2, m_row3, m_row4,
        input  y_out, done, busy
    );

    modport slave (
        input  enable, first, bitwidth, m_row1, m_row2, m_row3, m_row4,
        output y_out, done, busy
    );
endinterface

// File: rtl/win22_a.sv
// rtl/win22_a.sv - Winograd F(2x2,3x3) inverse transform Y = A^T*M*A with cross-channel accumulation
module win22_a (
    input  logic      clk,
    input  logic      rst,
    win22_a_if.slave  bus
);
    typedef enum logic [2:0] {S_IDLE, S_ROW, S_COL, S_ACC, S_OUT} state_t;

    state_t              state;
    logic [3:0][15:0]    m_r [4];
    logic                dual_r;
    logic                clear_r;
    logic signed [17:0]  ta [2][4];
    logic signed [17:0]  tb [2][4];
    logic signed [19:0]  ya [4];
    logic signed [19:0]  yb [4];
    logic signed [23:0]  acc_a [4];
    logic signed [23:0]  acc_b [4];
    logic signed [23:0]  acc_a_nxt [4];
    logic signed [23:0]  acc_b_nxt [4];
    logic [3:0][15:0]    y_out_r;
    logic                done_r;
    logic                busy_r;
    logic                dual_in;

    assign dual_in  = (bus.bitwidth == 2'b11);
    assign bus.y_out = y_out_r;
    assign bus.done  = done_r;
    assign bus.busy  = busy_r;

    // Path A carries the full 16-bit lane, or the low byte in dual mode; path B is the high byte.
    function automatic logic signed [17:0] lo_ext(input logic [15:0] v, input logic dual);
        return dual ? {{10{v[7]}}, v[7:0]} : {{2{v[15]}}, v};
    endfunction

    function automatic logic signed [17:0] hi_ext(input logic [15:0] v);
        return {{10{v[15]}}, v[15:8]};
    endfunction

    function automatic logic signed [19:0] x20(input logic signed [17:0] v);
        return {{2{v[17]}}, v};
    endfunction

    function automatic logic signed [23:0] x24(input logic signed [19:0] v);
        return {{4{v[19]}}, v};
    endfunction

    function automatic logic [15:0] sat16(input logic signed [23:0] v);
        if (v > 24'sd32767)
            return 16'h7fff;
        if (v < -24'sd32768)
            return 16'h8000;
        return v[15:0];
    endfunction

    function automatic logic [7:0] sat8(input logic signed [23:0] v);
        if (v > 24'sd127)
            return 8'h7f;
        if (v < -24'sd128)
            return 8'h80;
        return v[7:0];
    endfunction

    // Next accumulator values feed both the ACC update and the saturated output in the same edge.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            acc_a_nxt[k] = (clear_r ? 24'sd0 : acc_a[k]) + x24(ya[k]);
            acc_b_nxt[k] = (clear_r ? 24'sd0 : acc_b[k]) + x24(yb[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            done_r  <= 1'b0;
            busy_r  <= 1'b0;
            y_out_r <= '0;
            dual_r  <= 1'b0;
            clear_r <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                acc_a[k] <= '0;
                acc_b[k] <= '0;
            end
        end else begin
            done_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.enable) begin
                        m_r[0]  <= bus.m_row1;
                        m_r[1]  <= bus.m_row2;
                        m_r[2]  <= bus.m_row3;
                        m_r[3]  <= bus.m_row4;
                        clear_r <= bus.first || (dual_in != dual_r);
                        dual_r  <= dual_in;
                        busy_r  <= 1'b1;
                        state   <= S_ROW;
                    end
                end
                S_ROW: begin
                    for (int j = 0; j < 4; j++) begin
                        ta[0][j] <= lo_ext(m_r[0][3-j], dual_r) + lo_ext(m_r[1][3-j], dual_r)
                                  + lo_ext(m_r[2][3-j], dual_r);
                        ta[1][j] <= lo_ext(m_r[1][3-j], dual_r) - lo_ext(m_r[2][3-j], dual_r)
                                  - lo_ext(m_r[3][3-j], dual_r);
                        tb[0][j] <= hi_ext(m_r[0][3-j]) + hi_ext(m_r[1][3-j]) + hi_ext(m_r[2][3-j]);
                        tb[1][j] <= hi_ext(m_r[1][3-j]) - hi_ext(m_r[2][3-j]) - hi_ext(m_r[3][3-j]);
                    end
                    state <= S_COL;
                end
                S_COL: begin
                    for (int r = 0; r < 2; r++) begin
                        ya[2*r]   <= x20(ta[r][0]) + x20(ta[r][1]) + x20(ta[r][2]);
                        ya[2*r+1] <= x20(ta[r][1]) - x20(ta[r][2]) - x20(ta[r][3]);
                        yb[2*r]   <= x20(tb[r][0]) + x20(tb[r][1]) + x20(tb[r][2]);
                        yb[2*r+1] <= x20(tb[r][1]) - x20(tb[r][2]) - x20(tb[r][3]);
                    end
                    state <= S_ACC;
                end
                S_ACC: begin
                    for (int k = 0; k < 4; k++) begin
                        acc_a[k]     <= acc_a_nxt[k];
                        acc_b[k]     <= acc_b_nxt[k];
                        y_out_r[3-k] <= dual_r ? {sat8(acc_b_nxt[k]), sat8(acc_a_nxt[k])}
                                               : sat16(acc_a_nxt[k]);
                    end
                    done_r <= 1'b1;
                    state  <= S_OUT;
                end
                S_OUT: begin
                    busy_r <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_win22_a.sv
// tb/tb_win22_a.sv - self-checking bench for win22_a against a matrix-level reference model
module tb_win22_a;
    logic clk = 1'b0;
    logic rst;

    win22_a_if bus();
    win22_a dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    int macc_a [4];
    int macc_b [4];
    bit mdual;
    int at_m [2][4] = '{'{1, 1, 1, 0}, '{0, 1, -1, -1}};

    typedef struct {
        logic [15:0] lane;
        logic        first;
        logic [1:0]  bw;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int wrap24(input int x);
        return (x <<< 8) >>> 8;
    endfunction

    function automatic logic [15:0] msat16(input int a);
        if (a > 32767) return 16'h7fff;
        if (a < -32768) return 16'h8000;
        return 16'(a);
    endfunction

    function automatic logic [7:0] msat8(input int a);
        if (a > 127) return 8'h7f;
        if (a < -128) return 8'h80;
        return 8'(a);
    endfunction

    function automatic int elem(input logic [15:0] v, input bit dual, input int s);
        if (!dual) return (s == 0) ? int'($signed(v)) : 0;
        return (s == 0) ? int'($signed(v[7:0])) : int'($signed(v[15:8]));
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 4; k++) begin
            macc_a[k] = 0;
            macc_b[k] = 0;
        end
        mdual = 1'b0;
    endfunction

    // Y = A^T * M * A per sub-tile, then accumulate with 24-bit wrap and saturate.
    function automatic logic [63:0] model_tile(input logic [63:0] rows [4], input bit first,
                                               input logic [1:0] bw);
        bit dual;
        bit clr;
        int ya;
        int yb;
        int k;
        logic [15:0] v;
        logic [63:0] res;
        dual = (bw == 2'b11);
        clr  = first || (dual != mdual);
        res  = '0;
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 2; c++) begin
                ya = 0;
                yb = 0;
                for (int i = 0; i < 4; i++) begin
                    for (int j = 0; j < 4; j++) begin
                        v  = rows[i][63-16*j -: 16];
                        ya += at_m[r][i] * elem(v, dual, 0) * at_m[c][j];
                        yb += at_m[r][i] * elem(v, dual, 1) * at_m[c][j];
                    end
                end
                k = 2*r + c;
                macc_a[k] = wrap24((clr ? 0 : macc_a[k]) + ya);
                macc_b[k] = wrap24((clr ? 0 : macc_b[k]) + yb);
                res[63-16*k -: 16] = dual ? {msat8(macc_b[k]), msat8(macc_a[k])} : msat16(macc_a[k]);
            end
        end
        mdual = dual;
        return res;
    endfunction

    task automatic drive(input bit en, input bit first, input logic [1:0] bw, input logic [63:0] rows [4]);
        bus.enable   = en;
        bus.first    = first;
        bus.bitwidth = bw;
        bus.m_row1   = rows[0];
        bus.m_row2   = rows[1];
        bus.m_row3   = rows[2];
        bus.m_row4   = rows[3];
    endtask

    task automatic run_tile(input logic [63:0] rows [4], input bit first, input logic [1:0] bw,
                            input logic [63:0] exp, input string name);
        int cyc;
        bit seen;
        bit busy1;
        logic [63:0] junk [4];
        @(negedge clk);
        drive(1'b1, first, bw, rows);
        cyc   = 0;
        seen  = 1'b0;
        busy1 = 1'b0;
        while (!seen && cyc < 10) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            for (int i = 0; i < 4; i++) junk[i] = {$urandom, $urandom};
            drive(1'b0, 1'($urandom), 2'($urandom), junk);
            if (cyc == 1) busy1 = bus.busy;
            seen = bus.done;
        end
        check($sformatf("%s_busy1", name), 64'(busy1), 64'd1);
        check($sformatf("%s_latency", name), 64'(cyc), 64'd4);
        check($sformatf("%s_y", name), bus.y_out, exp);
        @(negedge clk);
        check($sformatf("%s_done_pulse", name), 64'(bus.done), 64'd0);
        check($sformatf("%s_idle", name), 64'(bus.busy), 64'd0);
    endtask

    function automatic void rep_rows(input logic [15:0] lane, output logic [63:0] rows [4]);
        for (int i = 0; i < 4; i++) rows[i] = {4{lane}};
    endfunction

    initial begin
        logic [63:0] rows [4];
        logic [63:0] exp;
        logic [15:0] l;
        int ndone;
        bit f;
        logic [1:0] b;

        vecs[0] = '{16'h0001, 1'b1, 2'b00, 64'h0009_FFFD_FFFD_0001};
        vecs[1] = '{16'h0001, 1'b0, 2'b00, 64'h0012_FFFA_FFFA_0002};
        vecs[2] = '{16'h0001, 1'b1, 2'b00, 64'h0009_FFFD_FFFD_0001};
        vecs[3] = '{16'h7FFF, 1'b1, 2'b00, 64'h7FFF_8000_8000_7FFF};
        vecs[4] = '{16'h0201, 1'b0, 2'b11, 64'h1209_FAFD_FAFD_0201};

        model_reset();
        rst = 1'b1;
        rep_rows(16'h0000, rows);
        drive(1'b0, 1'b0, 2'b00, rows);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_y", bus.y_out, 64'd0);
        check("reset_done", 64'(bus.done), 64'd0);
        check("reset_busy", 64'(bus.busy), 64'd0);

        rep_rows(16'h0001, rows);
        drive(1'b1, 1'b1, 2'b00, rows);
        @(negedge clk);
        rst = 1'b0;
        bus.enable = 1'b0;
        ndone = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        check("rst_enable_done", 64'(ndone), 64'd0);
        check("rst_enable_busy", 64'(bus.busy), 64'd0);

        for (int v = 0; v < 5; v++) begin
            rep_rows(vecs[v].lane, rows);
            exp = model_tile(rows, vecs[v].first, vecs[v].bw);
            run_tile(rows, vecs[v].first, vecs[v].bw, vecs[v].exp, $sformatf("vec%0d", v));
        end

        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < 4; i++) begin
                if (n % 2 == 0) begin
                    rows[i] = {$urandom, $urandom};
                end else begin
                    for (int j = 0; j < 4; j++) begin
                        l = 16'($urandom_range(0, 200)) - 16'd100;
                        rows[i][63-16*j -: 16] = l;
                    end
                end
            end
            f = ($urandom_range(0, 3) == 0);
            b = 2'($urandom_range(0, 3));
            exp = model_tile(rows, f, b);
            run_tile(rows, f, b, exp, $sformatf("rnd%0d", n));
        end

        rep_rows(16'h0001, rows);
        exp = model_tile(rows, 1'b1, 2'b00);
        @(negedge clk);
        drive(1'b1, 1'b1, 2'b00, rows);
        ndone = 0;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.done) ndone++;
            if (c == 4) check("ignore_en_y", bus.y_out, exp);
            rep_rows(16'h7FFF, rows);
            drive(1'b1, 1'b1, 2'b11, rows);
        end
        @(posedge clk);
        @(negedge clk);
        bus.enable = 1'b0;
        check("ignore_en_out_busy", 64'(bus.busy), 64'd0);
        repeat (6) begin
            if (bus.done) ndone++;
            @(negedge clk);
        end
        check("ignore_en_one_done", 64'(ndone), 64'd1);

        rep_rows(16'h0001, rows);
        @(negedge clk);
        drive(1'b1, 1'b1, 2'b00, rows);
        @(posedge clk);
        @(negedge clk);
        bus.enable = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("abort_done", 64'(bus.done), 64'd0);
        check("abort_y", bus.y_out, 64'd0);
        check("abort_busy", 64'(bus.busy), 64'd0);
        ndone = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        check("abort_no_done", 64'(ndone), 64'd0);
        model_reset();
        exp = model_tile(rows, 1'b0, 2'b00);
        run_tile(rows, 1'b0, 2'b00, 64'h0009_FFFD_FFFD_0001, "after_abort");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/win22_a.md
# win22_a

Winograd F(2x2,3x3) output (inverse) transform with cross-channel accumulation. It takes one 4x4 element-wise product tile M per start, computes Y = A^T·M·A, and adds Y into internal per-output accumulators. It emits the saturated 2x2 result after every tile. It sits downstream of the element-wise multiplier array. Its input row packing and `bitwidth` modes match the kernel-transform side (`win33_g`).

## Interface
- No parameters.
- `clk` in 1: rising-edge clock.
- `rst` in 1: synchronous, active-high reset.
- `enable` in 1: start; sampled only in IDLE.
- `first` in 1: sampled with `enable`; clears the accumulators before this tile is added.
- `bitwidth` in 2: sampled with `enable`.
  - 2'b11: dual 8-bit mode.
  - Any other value: 16-bit mode.
- `m_row1`..`m_row4` in 64 each: row i of M, packed `{mi_1[63:48], mi_2[47:32], mi_3[31:16], mi_4[15:0]}`, signed lanes; sampled with `enable`.
- `y_out` out 64: `{y11, y12, y21, y22}`, 16-bit fields, registered, held until the next OUT.
- `done` out 1: one-cycle pulse when `y_out` updates.
- `busy` out 1: high in every state except IDLE.

## Operation
- A^T = [[1,1,1,0],[0,1,-1,-1]].
- Row stage, for j = 1..4:
  - t1_j = m1_j + m2_j + m3_j
  - t2_j = m2_j − m3_j − m4_j
- Column stage, for r = 1,2:
  - yr1 = tr_1 + tr_2 + tr_3
  - yr2 = tr_2 − tr_3 − tr_4
- FSM, one state per cycle: IDLE → ROW → COL → ACC → OUT → IDLE.
  - IDLE: on `enable`=1, capture `m_row*`, `first` and `bitwidth`, then go to ROW. Otherwise stay in IDLE.
  - ROW: register t1/t2 (18-bit signed in 16-bit mode).
  - COL: register the four y values (20-bit signed).
  - ACC: acc_k ← (clear ? 0 : acc_k) + y_k. Accumulators are 24-bit signed and wrap on overflow.
  - OUT: update `y_out` with the saturated accumulators, pulse `done`, return to IDLE.
- 16-bit mode: each field of `y_out` is sat16(acc). Saturation range is 0x8000..0x7FFF.
- Dual 8-bit mode:
  - Each 16-bit lane holds two independent tiles: A in [7:0] and B in [15:8], both signed.
  - Eight accumulators are used, four per tile, each 24-bit.
  - Each output field is {sat8(accB), sat8(accA)}. Saturation range is 0x80..0x7F.
- The clear condition is `first`=1, or `bitwidth` mode differs from the mode of the previously accepted tile. A mode change forces a clear.
- `enable` outside IDLE is ignored, including in the OUT cycle. It is not queued.
- Inputs need only be valid in the `enable` cycle. Later input changes do not affect the tile in flight.

## Timing
- Reset values: state IDLE, `y_out`=0, `done`=0, `busy`=0, all accumulators 0, stored mode = 16-bit.
- Latency: `enable` accepted at cycle 0. `busy`=1 in cycles 1–4. `done`=1 and the new `y_out` both appear in cycle 4.
- Throughput: one tile per 5 cycles. The earliest next accept is cycle 5.
- `done` is high for exactly one cycle per accepted tile.
- `rst` in any state aborts the tile. The block returns to IDLE with reset values next cycle; no `done` is issued and the accumulators are cleared.
- `rst` and `enable` in the same cycle: `rst` wins and the tile is not accepted.

## Test plan
- Reset: assert `rst` for 2 cycles → `y_out`=0, `done`=0, `busy`=0. `enable` in the same cycle as `rst` gives no `done` 4 cycles later.
- 16-bit, `first`=1, all lanes 0x0001 → `done` in cycle 4 with `y_out`=0x0009_FFFD_FFFD_0001.
- Accumulate: repeat the previous tile with `first`=0 → `y_out`=0x0012_FFFA_FFFA_0002. A third tile with `first`=1 → 0x0009_FFFD_FFFD_0001.
- Saturation: all lanes 0x7FFF, `first`=1 → `y_out`=0x7FFF_8000_8000_7FFF.
- Dual 8-bit: `bitwidth`=2'b11, all lanes 0x0201, `first`=0 after a 16-bit tile (mode change forces a clear) → `y_out`=0x1209_FAFD_FAFD_0201.
- Robustness, tile X accepted with all lanes 0x0001 and `first`=1:
  - `enable` pulses in cycles 1–4 are ignored; exactly one `done` appears.
  - Then start tile Y, also all lanes 0x0001 with `first`=1, and assert `rst` during its COL cycle. Expect no `done`, `y_out`=0 and `busy`=0 in the following cycle, and a subsequent `first`=0 tile yields 0x0009_FFFD_FFFD_0001.
